// File: rtl/dma_pcie_wb_ctxt_pkg.sv
// ---------------------------------------------------------------------------
// dma_pcie_wb_ctxt_pkg
// Shared types for the writeback-context RAM controller: entry index and
// entry data types, the controller state enum, the read-pipeline tag and
// the even byte-parity helper used on both the write and the read side.
// ---------------------------------------------------------------------------
package dma_pcie_wb_ctxt_pkg;

  localparam int ENT_IDX_W  = 11;   // {dir, qid[9:0]}
  localparam int ENT_DATA_W = 64;
  localparam int ENT_PAR_W  = ENT_DATA_W / 8;
  localparam int RAM_DATA_W = 128;  // RAM read port is wider than an entry

  typedef logic [ENT_IDX_W-1:0]  ent_idx_t;
  typedef logic [ENT_DATA_W-1:0] ent_data_t;
  typedef logic [ENT_PAR_W-1:0]  ent_par_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctl_state_e;

  // One slot of the read pipeline: travels alongside the RAM read.
  typedef struct packed {
    logic     vld;
    ent_idx_t qid;
  } rd_tag_t;

  // Even parity per byte: bit i is the XOR of byte i.
  function automatic ent_par_t byte_par(input ent_data_t d);
    ent_par_t p;
    for (int i = 0; i < ENT_PAR_W; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dma_pcie_mi_8Bx2048_4Bwe_ram_if.sv
// ---------------------------------------------------------------------------
// dma_pcie_mi_8Bx2048_4Bwe_ram_if
// Port bundle of the 2048 x 8B writeback-context RAM.
//   m : controller side (drives write/read requests, receives read data)
//   s : RAM side
// Signals:
//   wen[1:0]   per-32-bit write enable      wadr  write entry index
//   wdat[63:0] write data                   wpar  even byte parity of wdat
//   ren        read enable                  radr  read entry index
//   rdat[127:0] read data (only [63:0] carries the entry)
//   rpar[7:0]  stored byte parity           rsbe/rdbe single/double bit error
// ---------------------------------------------------------------------------
interface dma_pcie_mi_8Bx2048_4Bwe_ram_if;
  import dma_pcie_wb_ctxt_pkg::*;

  logic [1:0]            wen;
  ent_idx_t              wadr;
  ent_data_t             wdat;
  ent_par_t              wpar;
  logic                  ren;
  ent_idx_t              radr;
  logic [RAM_DATA_W-1:0] rdat;
  ent_par_t              rpar;
  logic                  rsbe;
  logic                  rdbe;

  modport m (
    output wen, wadr, wdat, wpar, ren, radr,
    input  rdat, rpar, rsbe, rdbe
  );

  modport s (
    input  wen, wadr, wdat, wpar, ren, radr,
    output rdat, rpar, rsbe, rdbe
  );
endinterface

// File: rtl/dma_pcie_wb_ctxt_ctl_if.sv
// ---------------------------------------------------------------------------
// dma_pcie_wb_ctxt_ctl_if
// Request/response bundle between the queue-context engine and the
// writeback-context controller.
//   master : queue-context engine (issues writes/reads, sinks responses)
//   slave  : dma_pcie_wb_ctxt_ctl
// Write:    wr_vld/wr_rdy, wr_qid, wr_be[1:0], wr_data[63:0]
// Read:     rd_vld/rd_rdy, rd_qid
// Response: rsp_vld (no backpressure), rsp_qid, rsp_data, rsp_sbe, rsp_err
// ---------------------------------------------------------------------------
interface dma_pcie_wb_ctxt_ctl_if;
  import dma_pcie_wb_ctxt_pkg::*;

  logic      wr_vld;
  logic      wr_rdy;
  ent_idx_t  wr_qid;
  logic [1:0] wr_be;
  ent_data_t wr_data;
  logic      rd_vld;
  logic      rd_rdy;
  ent_idx_t  rd_qid;
  logic      rsp_vld;
  ent_idx_t  rsp_qid;
  ent_data_t rsp_data;
  logic      rsp_sbe;
  logic      rsp_err;

  modport master (
    output wr_vld, wr_qid, wr_be, wr_data, rd_vld, rd_qid,
    input  wr_rdy, rd_rdy, rsp_vld, rsp_qid, rsp_data, rsp_sbe, rsp_err
  );

  modport slave (
    input  wr_vld, wr_qid, wr_be, wr_data, rd_vld, rd_qid,
    output wr_rdy, rd_rdy, rsp_vld, rsp_qid, rsp_data, rsp_sbe, rsp_err
  );
endinterface

// File: rtl/dma_pcie_wb_ctxt_rdpipe.sv
// ---------------------------------------------------------------------------
// dma_pcie_wb_ctxt_rdpipe
// Carries {valid, qid} of each RAM read for RD_LAT cycles so it lines up
// with the RAM data, checks byte parity, and registers the response.
// Also keeps the saturating single-bit / uncorrectable error counters.
// Ports:
//   clk, rst            clock, synchronous active-high clear
//   ren_i, radr_i       RAM read request as driven to the RAM
//   rdat_i, rpar_i      entry data and stored parity from the RAM
//   rsbe_i, rdbe_i      RAM corrected / uncorrectable error flags
//   rsp_*_o             registered read response
//   sbe_cnt_o, err_cnt_o saturating error counters
// ---------------------------------------------------------------------------
module dma_pcie_wb_ctxt_rdpipe
  import dma_pcie_wb_ctxt_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ren_i,
  input  ent_idx_t         radr_i,
  input  ent_data_t        rdat_i,
  input  ent_par_t         rpar_i,
  input  logic             rsbe_i,
  input  logic             rdbe_i,
  output logic             rsp_vld_o,
  output ent_idx_t         rsp_qid_o,
  output ent_data_t        rsp_data_o,
  output logic             rsp_sbe_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] sbe_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  rd_tag_t [RD_LAT-1:0] tag_q;
  rd_tag_t [RD_LAT-1:0] tag_d;

  // Stage 0 captures the read as it is presented to the RAM; the last stage
  // is valid in the same cycle the RAM returns the data.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      assign tag_d[gi] = '{vld: ren_i, qid: radr_i};
    end else begin : g_body
      assign tag_d[gi] = tag_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  rd_tag_t tail;
  logic    par_bad;
  logic    err_d;
  logic    sbe_d;

  assign tail    = tag_q[RD_LAT-1];
  assign par_bad = |(byte_par(rdat_i) ^ rpar_i);
  assign err_d   = par_bad | rdbe_i;
  // A corrected error is not worth reporting if the word is unusable anyway.
  assign sbe_d   = rsbe_i & ~err_d;

  logic             rsp_vld_q;
  ent_idx_t         rsp_qid_q;
  ent_data_t        rsp_data_q;
  logic             rsp_sbe_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] sbe_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_qid_q  <= '0;
      rsp_data_q <= '0;
      rsp_sbe_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      sbe_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      rsp_vld_q <= tail.vld;
      rsp_sbe_q <= tail.vld & sbe_d;
      rsp_err_q <= tail.vld & err_d;
      if (tail.vld) begin
        rsp_qid_q  <= tail.qid;
        rsp_data_q <= rdat_i;
      end
      if (tail.vld && sbe_d && !(&sbe_cnt_q)) sbe_cnt_q <= sbe_cnt_q + 1'b1;
      if (tail.vld && err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_qid_o  = rsp_qid_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_sbe_o  = rsp_sbe_q;
  assign rsp_err_o  = rsp_err_q;
  assign sbe_cnt_o  = sbe_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/dma_pcie_wb_ctxt_ctl.sv
// ---------------------------------------------------------------------------
// dma_pcie_wb_ctxt_ctl
// Master-side controller of the 2048 x 8B writeback-context RAM (one 64-bit
// writeback base per queue: 1024 H2C + 1024 C2H). After reset it zeroes every
// entry, then accepts context writes and reads, generates byte parity on
// writes and returns parity-checked read responses at fixed latency.
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   req        request/response bundle (slave side)
//   ram        RAM port (controller side)
//   init_done  RAM clear complete
//   sbe_cnt    saturating count of responses with rsp_sbe
//   err_cnt    saturating count of responses with rsp_err
// ---------------------------------------------------------------------------
module dma_pcie_wb_ctxt_ctl
  import dma_pcie_wb_ctxt_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int NUM_ENT = 2048,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  dma_pcie_wb_ctxt_ctl_if.slave         req,
  dma_pcie_mi_8Bx2048_4Bwe_ram_if.m     ram,
  output logic                          init_done,
  output logic [CNT_W-1:0]              sbe_cnt,
  output logic [CNT_W-1:0]              err_cnt
);

  ctl_state_e state_q, state_d;
  ent_idx_t   idx_q, idx_d;
  logic       init_done_q, init_done_d;

  logic [1:0] wen_q, wen_d;
  ent_idx_t   wadr_q, wadr_d;
  ent_data_t  wdat_q, wdat_d;
  ent_par_t   wpar_q, wpar_d;
  logic       ren_q, ren_d;
  ent_idx_t   radr_q, radr_d;

  logic wr_rdy_w;
  logic rd_rdy_w;
  logic collision;

  // A read of an entry that is being written this very cycle must wait one
  // cycle so it is driven to the RAM after the write lands.
  assign collision = req.wr_vld & req.rd_vld & (req.wr_qid == req.rd_qid) &
                     (req.wr_be != 2'b00);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    wen_d       = 2'b00;
    wadr_d      = wadr_q;
    wdat_d      = wdat_q;
    wpar_d      = wpar_q;
    ren_d       = 1'b0;
    radr_d      = radr_q;
    wr_rdy_w    = 1'b0;
    rd_rdy_w    = 1'b0;

    unique case (state_q)
      INIT: begin
        wen_d  = 2'b11;
        wadr_d = idx_q;
        wdat_d = '0;
        wpar_d = '0;
        if (idx_q == ent_idx_t'(NUM_ENT - 1)) state_d = RUN;
        else                                  idx_d   = idx_q + 1'b1;
      end
      RUN: begin
        // init_done_q lags the state by one cycle, so handshakes open
        // together with init_done.
        init_done_d = 1'b1;
        wr_rdy_w    = init_done_q;
        rd_rdy_w    = init_done_q & ~collision;
        if (req.wr_vld && wr_rdy_w) begin
          wen_d  = req.wr_be;
          wadr_d = req.wr_qid;
          wdat_d = req.wr_data;
          wpar_d = byte_par(req.wr_data);
        end
        if (req.rd_vld && rd_rdy_w) begin
          ren_d  = 1'b1;
          radr_d = req.rd_qid;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      wen_q       <= 2'b00;
      wadr_q      <= '0;
      wdat_q      <= '0;
      wpar_q      <= '0;
      ren_q       <= 1'b0;
      radr_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      wen_q       <= wen_d;
      wadr_q      <= wadr_d;
      wdat_q      <= wdat_d;
      wpar_q      <= wpar_d;
      ren_q       <= ren_d;
      radr_q      <= radr_d;
    end
  end

  assign ram.wen  = wen_q;
  assign ram.wadr = wadr_q;
  assign ram.wdat = wdat_q;
  assign ram.wpar = wpar_q;
  assign ram.ren  = ren_q;
  assign ram.radr = radr_q;

  assign req.wr_rdy = wr_rdy_w;
  assign req.rd_rdy = rd_rdy_w;
  assign init_done  = init_done_q;

  // The upper half of the RAM read word carries nothing for this table.
  logic unused_rdat_hi;
  assign unused_rdat_hi = ^ram.rdat[RAM_DATA_W-1:ENT_DATA_W];

  dma_pcie_wb_ctxt_rdpipe #(
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .ren_i      (ren_q),
    .radr_i     (radr_q),
    .rdat_i     (ram.rdat[ENT_DATA_W-1:0]),
    .rpar_i     (ram.rpar),
    .rsbe_i     (ram.rsbe),
    .rdbe_i     (ram.rdbe),
    .rsp_vld_o  (req.rsp_vld),
    .rsp_qid_o  (req.rsp_qid),
    .rsp_data_o (req.rsp_data),
    .rsp_sbe_o  (req.rsp_sbe),
    .rsp_err_o  (req.rsp_err),
    .sbe_cnt_o  (sbe_cnt),
    .err_cnt_o  (err_cnt)
  );

endmodule

// File: tb/tb_dma_pcie_wb_ctxt_ctl.sv
// ---------------------------------------------------------------------------
// tb_dma_pcie_wb_ctxt_ctl
// Drives dma_pcie_wb_ctxt_ctl against a behavioural RAM with RD_LAT=2 and
// error injection, and compares every cycle against a table-level model:
// a 2048-entry array, a queue of expected responses with due cycles, and
// saturating counters.
// ---------------------------------------------------------------------------
module tb_dma_pcie_wb_ctxt_ctl;
  import dma_pcie_wb_ctxt_pkg::*;

  localparam int RD_LAT  = 2;
  localparam int NUM_ENT = 2048;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_pcie_wb_ctxt_ctl_if          req ();
  dma_pcie_mi_8Bx2048_4Bwe_ram_if  ram ();
  logic             init_done;
  logic [CNT_W-1:0] sbe_cnt;
  logic [CNT_W-1:0] err_cnt;

  dma_pcie_wb_ctxt_ctl #(
    .RD_LAT  (RD_LAT),
    .NUM_ENT (NUM_ENT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ram       (ram),
    .init_done (init_done),
    .sbe_cnt   (sbe_cnt),
    .err_cnt   (err_cnt)
  );

  // ---------------- behavioural RAM (two read register stages) -----------
  logic [63:0] mem  [NUM_ENT];
  logic [7:0]  pmem [NUM_ENT];
  logic [63:0] s1_dat;
  logic [7:0]  s1_par;
  logic        s1_sbe, s1_dbe;
  bit          inj_par, inj_sbe, inj_dbe;

  always @(posedge clk) begin
    if (ram.wen[0]) begin
      mem[ram.wadr][31:0] <= ram.wdat[31:0];
      pmem[ram.wadr][3:0] <= ram.wpar[3:0];
    end
    if (ram.wen[1]) begin
      mem[ram.wadr][63:32] <= ram.wdat[63:32];
      pmem[ram.wadr][7:4]  <= ram.wpar[7:4];
    end
    s1_dat   <= mem[ram.radr];
    s1_par   <= pmem[ram.radr] ^ (inj_par ? 8'h08 : 8'h00);
    s1_sbe   <= inj_sbe;
    s1_dbe   <= inj_dbe;
    ram.rdat <= {$urandom, $urandom, s1_dat};
    ram.rpar <= s1_par;
    ram.rsbe <= s1_sbe;
    ram.rdbe <= s1_dbe;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [10:0] qid;
    logic [63:0] data;
    bit          err;
    bit          sbe;
  } exp_t;

  exp_t        eq[$];
  logic [63:0] mm [NUM_ENT];
  int          m_err, m_sbe;
  bit          m_run;
  int          rel;
  int          checks, errors;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit wv, input logic [10:0] wq, input logic [1:0] wbe,
                     input logic [63:0] wd, input bit rv, input logic [10:0] rq);
    req.wr_vld  = wv;
    req.wr_qid  = wq;
    req.wr_be   = wbe;
    req.wr_data = wd;
    req.rd_vld  = rv;
    req.rd_qid  = rq;
  endtask

  // Sample at the falling edge: responses, handshake and model update.
  task automatic sample();
    exp_t e;
    logic coll;
    @(negedge clk);
    if (eq.size() > 0 && eq[0].due == rel) begin
      e = eq.pop_front();
      if (e.err && m_err < 65535) m_err++;
      if (e.sbe && m_sbe < 65535) m_sbe++;
      chk("rsp", {req.rsp_vld, req.rsp_qid, req.rsp_data, req.rsp_sbe, req.rsp_err},
          {1'b1, e.qid, e.data, e.sbe, e.err});
      chk("cnt", {sbe_cnt, err_cnt}, {m_sbe[15:0], m_err[15:0]});
    end else begin
      chk("rsp_idle", {255'd0, req.rsp_vld}, 256'd0);
    end
    if (!rst) begin
      coll = req.wr_vld && req.rd_vld && (req.wr_qid == req.rd_qid) && (req.wr_be != 2'b00);
      chk("rdy", {req.wr_rdy, req.rd_rdy}, {m_run, m_run && !coll});
      if (m_run && req.rd_vld && !coll) begin
        e.due  = rel + RD_LAT + 2;
        e.qid  = req.rd_qid;
        e.data = mm[req.rd_qid];
        e.err  = inj_par || inj_dbe;
        e.sbe  = inj_sbe && !(inj_par || inj_dbe);
        eq.push_back(e);
      end
      if (m_run && req.wr_vld) begin
        if (req.wr_be[0]) mm[req.wr_qid][31:0]  = req.wr_data[31:0];
        if (req.wr_be[1]) mm[req.wr_qid][63:32] = req.wr_data[63:32];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle(input int n);
    drv(0, 11'd0, 2'b00, 64'd0, 0, 11'd0);
    repeat (n) step();
  endtask

  task automatic rd1(input logic [10:0] q);
    drv(0, 11'd0, 2'b00, 64'd0, 1, q);
    step();
    idle(RD_LAT + 4);
  endtask

  // Reset, then follow the RAM clear cycle by cycle.
  task automatic run_init();
    rst = 1'b1;
    drv(0, 11'd0, 2'b00, 64'd0, 0, 11'd0);
    eq.delete();
    m_run = 0;
    m_err = 0;
    m_sbe = 0;
    inj_par = 0; inj_sbe = 0; inj_dbe = 0;
    repeat (3) step();
    rst = 1'b0;
    rel = 0;
    // Requests held high throughout init must not be accepted.
    drv(1, 11'h000, 2'b11, 64'hDEAD_BEEF_0BAD_F00D, 1, 11'h000);
    for (int k = 0; k <= NUM_ENT + 1; k++) begin
      if (k == NUM_ENT + 1) begin
        m_run = 1;
        drv(0, 11'd0, 2'b00, 64'd0, 0, 11'd0);
      end
      sample();
      if (k == 0) begin
        chk("rst_rsp", {req.wr_rdy, req.rd_rdy, req.rsp_vld, req.rsp_qid, req.rsp_data,
                        req.rsp_sbe, req.rsp_err, init_done, sbe_cnt, err_cnt}, 256'd0);
        chk("rst_ram", {ram.wen, ram.ren, ram.wadr, ram.radr, ram.wdat, ram.wpar}, 256'd0);
      end else if (k <= NUM_ENT) begin
        chk("init_wr", {init_done, ram.wen, ram.wadr, ram.wdat, ram.wpar},
            {1'b0, 2'b11, 11'(k - 1), 64'd0, 8'd0});
      end else begin
        chk("init_done", {init_done, ram.wen}, {1'b1, 2'b00});
      end
      advance();
    end
    for (int i = 0; i < NUM_ENT; i++) mm[i] = 64'd0;
  endtask

  initial begin
    logic [10:0] wq;
    checks = 0;
    errors = 0;
    rel    = 0;
    rst    = 1'b1;
    inj_par = 0; inj_sbe = 0; inj_dbe = 0;
    drv(0, 11'd0, 2'b00, 64'd0, 0, 11'd0);
    @(posedge clk);
    #1;

    run_init();

    // Cleared entry at the top of the C2H half.
    rd1(11'h7FF);

    // Full write, then low-word-only write, then read back.
    drv(1, 11'h005, 2'b11, 64'h1122_3344_5566_7788, 0, 11'd0); step();
    drv(1, 11'h005, 2'b01, 64'hAAAA_AAAA_0000_0000, 0, 11'd0); step();
    rd1(11'h005);

    // Same-cycle write/read of one entry: read waits a cycle, sees new data.
    drv(1, 11'h405, 2'b11, 64'h0123_4567_89AB_CDEF, 1, 11'h405); step();
    drv(0, 11'd0, 2'b00, 64'd0, 1, 11'h405); step();
    idle(RD_LAT + 4);

    // Zero byte-enable write to the same entry does not block the read.
    drv(1, 11'h405, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 11'h405); step();
    idle(RD_LAT + 4);

    // Back-to-back reads with a concurrent stream of writes elsewhere.
    drv(1, 11'h010, 2'b11, 64'h1111_0000_0000_0010, 1, 11'h001); step();
    drv(1, 11'h010, 2'b10, 64'h2222_0000_0000_0020, 1, 11'h002); step();
    drv(1, 11'h010, 2'b01, 64'h3333_0000_0000_0030, 1, 11'h003); step();
    idle(RD_LAT + 4);
    rd1(11'h010);

    // Error injection.
    inj_par = 1; rd1(11'h005); inj_par = 0;
    chk("err_cnt_1", err_cnt, 16'd1);
    inj_sbe = 1; rd1(11'h405); inj_sbe = 0;
    chk("sbe_cnt_1", sbe_cnt, 16'd1);
    inj_par = 1; inj_sbe = 1; rd1(11'h010); inj_par = 0; inj_sbe = 0;
    chk("sbe_masked", {sbe_cnt, err_cnt}, {16'd1, 16'd2});
    inj_dbe = 1; rd1(11'h7FF); inj_dbe = 0;
    chk("dbe_err", err_cnt, 16'd3);

    // Random mix over a few entries so collisions happen often.
    for (int i = 0; i < 800; i++) begin
      wq = {1'($urandom_range(0, 1)), 7'd0, 3'($urandom_range(0, 7))};
      drv(1'($urandom_range(0, 1)), wq, 2'($urandom_range(0, 3)), {$urandom, $urandom},
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? wq
                                      : {1'($urandom_range(0, 1)), 7'd0, 3'($urandom_range(0, 7))});
      step();
    end
    idle(RD_LAT + 4);

    // Saturation of the uncorrectable-error counter.
    inj_par = 1;
    for (int i = 0; i < 65536; i++) begin
      drv(0, 11'd0, 2'b00, 64'd0, 1, 11'($urandom_range(0, NUM_ENT - 1)));
      step();
    end
    idle(RD_LAT + 4);
    inj_par = 0;
    chk("err_sat", err_cnt, 16'hFFFF);

    // Reset with two reads in flight: no responses, init restarts at 0.
    drv(0, 11'd0, 2'b00, 64'd0, 1, 11'h001); step();
    drv(0, 11'd0, 2'b00, 64'd0, 1, 11'h002); step();
    run_init();
    rd1(11'h005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
